pipe_skid_reader16: RTL and testbench

//  Downstream (reader) end of a 16-bit pipeline-register stage in the RiscV core.

---
 rtl/pipe_skid_reader16.sv | 140 ++++++++++++++
 tb/tb_pipe_skid_reader16.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reader16.sv
// pipe_skid_reader16
//   Reader end of a pipeline-register stage. Words arrive over a valid/ready
//   handshake and are presented to the next stage through a 2-entry skid
//   buffer. Back-pressure never drops or duplicates a word. A synchronous
//   flush empties the buffer on a branch/trap redirect.
//
//   Optional feature: define PIPE_SKID_STATS_EN to add the stall_cnt port.
//   It counts cycles with out_valid=1 and out_ready=0, saturates at 16'hFFFF,
//   and is cleared only by rst.
//
// Ports
//   clk        in   1      clock, all state changes on posedge
//   rst        in   1      synchronous active-high reset
//   flush      in   1      synchronous clear of buffered words
//   in_valid   in   1      upstream word valid
//   in_data    in   WIDTH  upstream word
//   in_ready   out  1      buffer accepts a word this cycle (state != FULL)
//   out_valid  out  1      out_data holds a valid word (state != EMPTY)
//   out_data   out  WIDTH  head of buffer
//   out_ready  in   1      next stage takes out_data this cycle
//   occupancy  out  2      words held: 0, 1 or 2
//   stall_cnt  out  16     stall cycle counter (PIPE_SKID_STATS_EN only)
module pipe_skid_reader16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  // Every output is decoded from flops only, so there is no combinational
  // path from in_* or out_ready to any output.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Any handshake in the flush cycle is discarded, including the upstream word.
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            main_d = in_data;
          end else if (in_valid) begin
            // Head is stalled: park the new word in the skid entry.
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so in_valid is ignored.
          if (out_ready) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_SKID_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Flush does not clear the counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready) stall_cnt_d = sat_inc16(stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reader16.sv
module tb_pipe_skid_reader16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [1:0]  occupancy;
`ifdef PIPE_SKID_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  pipe_skid_reader16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] v, input logic [31:0] r,
                             input logic [31:0] occ);
    check({tag, "_out_valid"}, 32'(out_valid), v);
    check({tag, "_in_ready"},  32'(in_ready),  r);
    check({tag, "_occupancy"}, 32'(occupancy), occ);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;

    // Reset held for two cycles
    step(); step();
    check_state("reset", 0, 1, 0);
    check("reset_out_data", 32'(out_data), 32'h0000);
    rst = 1'b0;

    // Streaming 0001..0008 with out_ready=1: one-cycle latency, occupancy 1
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i); out_ready = 1'b1;
      step();
      check_state($sformatf("stream%0d", i), 1, 1, 1);
      check($sformatf("stream%0d_data", i), 32'(out_data), 32'(i));
    end
    in_valid = 1'b0;
    step();
    check_state("stream_drain", 0, 1, 0);

    // Fill to FULL under back-pressure, third word refused
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hA5A5;
    step();
    check_state("bp_one", 1, 1, 1);
    check("bp_one_data", 32'(out_data), 32'hA5A5);
    in_data = 16'h5A5A;
    step();
    check_state("bp_full", 1, 0, 2);
    check("bp_full_data", 32'(out_data), 32'hA5A5);
    in_data = 16'hFFFF;
    step();
    check_state("bp_refuse", 1, 0, 2);
    check("bp_refuse_data", 32'(out_data), 32'hA5A5);
    out_ready = 1'b1;                       // A5A5 leaves on this edge
    step();
    check_state("bp_pop1", 1, 1, 1);
    check("bp_pop1_data", 32'(out_data), 32'h5A5A);
    step();                                  // 5A5A leaves, FFFF accepted
    check_state("bp_pop2", 1, 1, 1);
    check("bp_pop2_data", 32'(out_data), 32'hFFFF);
    in_valid = 1'b0;
    step();
    check_state("bp_drain", 0, 1, 0);

    // BUSY hold: no input, no ready -> word stays
    in_valid = 1'b1; in_data = 16'h0C0C; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    check_state("busy_hold", 1, 1, 1);
    check("busy_hold_data", 32'(out_data), 32'h0C0C);
    out_ready = 1'b1;
    step();
    check_state("busy_hold_drain", 0, 1, 0);

    // Flush while FULL with a concurrent upstream word
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1111;
    step();
    in_data = 16'h2222;
    step();
    check_state("fl_full", 1, 0, 2);
    flush = 1'b1; in_data = 16'h3333;
    step();
    check_state("flush", 0, 1, 0);
    check("flush_data", 32'(out_data), 32'h0000);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_state("flush_after", 0, 1, 0);

    // Reset while FULL, then BEEF is the first word out
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    step();
    in_data = 16'h5678;
    step();
    check_state("rst_full", 1, 0, 2);
    rst = 1'b1; in_valid = 1'b0;
    step();
    check_state("rst_mid", 0, 1, 0);
    check("rst_mid_data", 32'(out_data), 32'h0000);
    rst = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1;
    step();
    check_state("rst_beef", 1, 1, 1);
    check("rst_beef_data", 32'(out_data), 32'hBEEF);
    in_valid = 1'b0;
    step();
    check_state("rst_beef_drain", 0, 1, 0);

`ifdef PIPE_SKID_STATS_EN
    // Stall counter: 10 stalls, flush keeps it, then saturation
    check("stall_init", 32'(stall_cnt), 0);
    in_valid = 1'b1; in_data = 16'h0042; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check("stall_10", 32'(stall_cnt), 10);
    flush = 1'b1; out_ready = 1'b1;         // not a stall cycle
    step();
    flush = 1'b0;
    check("stall_after_flush", 32'(stall_cnt), 10);
    check_state("stall_flush", 0, 1, 0);
    in_valid = 1'b1; in_data = 16'h0077; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check("stall_sat", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
